// File: rtl/sc_statemachine_fallcontrol_if.sv
// Control bundle between the falling-piece sequencer and the LED-matrix datapath:
// tick/move requests and comparator flags in, shift/load/commit pulses and status out.
interface sc_statemachine_fallcontrol_if #(
    parameter int unsigned FALLCONTROL_DATAWIDTH = 8
) ();
    logic                             SC_STATEMACHINE_FALLCONTROL_tick_In;
    logic                             SC_STATEMACHINE_FALLCONTROL_left_In;
    logic                             SC_STATEMACHINE_FALLCONTROL_right_In;
    logic                             SC_STATEMACHINE_FALLCONTROL_leftwall_In;
    logic                             SC_STATEMACHINE_FALLCONTROL_rightwall_In;
    logic                             SC_STATEMACHINE_FALLCONTROL_bottomside_In;
    logic                             SC_STATEMACHINE_FALLCONTROL_topside_In;
    logic                             SC_STATEMACHINE_FALLCONTROL_loadpiece_Out;
    logic                             SC_STATEMACHINE_FALLCONTROL_shiftdown_Out;
    logic                             SC_STATEMACHINE_FALLCONTROL_shiftleft_Out;
    logic                             SC_STATEMACHINE_FALLCONTROL_shiftright_Out;
    logic                             SC_STATEMACHINE_FALLCONTROL_commit_Out;
    logic                             SC_STATEMACHINE_FALLCONTROL_gameover_Out;
    logic [FALLCONTROL_DATAWIDTH-1:0] SC_STATEMACHINE_FALLCONTROL_landed_OutBUS;

    modport master (
        output SC_STATEMACHINE_FALLCONTROL_tick_In,
        output SC_STATEMACHINE_FALLCONTROL_left_In,
        output SC_STATEMACHINE_FALLCONTROL_right_In,
        output SC_STATEMACHINE_FALLCONTROL_leftwall_In,
        output SC_STATEMACHINE_FALLCONTROL_rightwall_In,
        output SC_STATEMACHINE_FALLCONTROL_bottomside_In,
        output SC_STATEMACHINE_FALLCONTROL_topside_In,
        input  SC_STATEMACHINE_FALLCONTROL_loadpiece_Out,
        input  SC_STATEMACHINE_FALLCONTROL_shiftdown_Out,
        input  SC_STATEMACHINE_FALLCONTROL_shiftleft_Out,
        input  SC_STATEMACHINE_FALLCONTROL_shiftright_Out,
        input  SC_STATEMACHINE_FALLCONTROL_commit_Out,
        input  SC_STATEMACHINE_FALLCONTROL_gameover_Out,
        input  SC_STATEMACHINE_FALLCONTROL_landed_OutBUS
    );

    modport slave (
        input  SC_STATEMACHINE_FALLCONTROL_tick_In,
        input  SC_STATEMACHINE_FALLCONTROL_left_In,
        input  SC_STATEMACHINE_FALLCONTROL_right_In,
        input  SC_STATEMACHINE_FALLCONTROL_leftwall_In,
        input  SC_STATEMACHINE_FALLCONTROL_rightwall_In,
        input  SC_STATEMACHINE_FALLCONTROL_bottomside_In,
        input  SC_STATEMACHINE_FALLCONTROL_topside_In,
        output SC_STATEMACHINE_FALLCONTROL_loadpiece_Out,
        output SC_STATEMACHINE_FALLCONTROL_shiftdown_Out,
        output SC_STATEMACHINE_FALLCONTROL_shiftleft_Out,
        output SC_STATEMACHINE_FALLCONTROL_shiftright_Out,
        output SC_STATEMACHINE_FALLCONTROL_commit_Out,
        output SC_STATEMACHINE_FALLCONTROL_gameover_Out,
        output SC_STATEMACHINE_FALLCONTROL_landed_OutBUS
    );
endinterface

// File: rtl/sc_statemachine_fallcontrol.sv
// Falling-piece sequencer: turns gravity ticks and move requests into one-cycle
// load/shift/commit pulses, with a lock delay, landed-piece counter and sticky game-over.
module sc_statemachine_fallcontrol #(
    parameter int unsigned FALLCONTROL_DATAWIDTH = 8,
    parameter int unsigned FALLCONTROL_LOCKTICKS = 2
) (
    input logic                          SC_STATEMACHINE_FALLCONTROL_CLOCK_50,
    input logic                          SC_STATEMACHINE_FALLCONTROL_RESET_InLow,
    sc_statemachine_fallcontrol_if.slave bus_io
);
    localparam int unsigned LockW =
        (FALLCONTROL_LOCKTICKS > 1) ? $clog2(FALLCONTROL_LOCKTICKS) : 1;
    localparam logic [LockW-1:0] LockLast = LockW'(FALLCONTROL_LOCKTICKS - 1);

    typedef enum logic [3:0] {
        StStart,
        StLoad,
        StCheckTop,
        StWait,
        StLeft,
        StRight,
        StDown,
        StCommit,
        StGameOver
    } state_e;

    state_e                           state_q, state_d;
    logic                             tickpend_q, tickpend_d;
    logic [LockW-1:0]                 lockcnt_q, lockcnt_d;
    logic [FALLCONTROL_DATAWIDTH-1:0] landed_q, landed_d;

    logic tick_in, tick_req, move_left, move_right, bottom_in, top_in;

    assign tick_in    = bus_io.SC_STATEMACHINE_FALLCONTROL_tick_In;
    assign bottom_in  = bus_io.SC_STATEMACHINE_FALLCONTROL_bottomside_In;
    assign top_in     = bus_io.SC_STATEMACHINE_FALLCONTROL_topside_In;
    assign tick_req   = tick_in | tickpend_q;
    assign move_left  = bus_io.SC_STATEMACHINE_FALLCONTROL_left_In &
                        ~bus_io.SC_STATEMACHINE_FALLCONTROL_leftwall_In;
    assign move_right = bus_io.SC_STATEMACHINE_FALLCONTROL_right_In &
                        ~bus_io.SC_STATEMACHINE_FALLCONTROL_rightwall_In;

    always_comb begin
        state_d    = state_q;
        // Ticks arriving while busy are remembered and served on the next WAIT cycle.
        tickpend_d = tickpend_q | tick_in;
        lockcnt_d  = lockcnt_q;
        landed_d   = landed_q;
        case (state_q)
            StStart:    state_d = StLoad;
            StLoad:     state_d = StCheckTop;
            StCheckTop: state_d = top_in ? StGameOver : StWait;
            StWait: begin
                if (move_left) begin
                    state_d    = StLeft;
                    tickpend_d = tick_req;
                end else if (move_right) begin
                    state_d    = StRight;
                    tickpend_d = tick_req;
                end else begin
                    tickpend_d = 1'b0;
                    if (tick_req && !bottom_in) begin
                        state_d   = StDown;
                        lockcnt_d = '0;
                    end else if (tick_req && lockcnt_q == LockLast) begin
                        state_d = StCommit;
                    end else if (tick_req) begin
                        lockcnt_d = lockcnt_q + 1'b1;
                    end
                end
            end
            StLeft, StRight, StDown: state_d = StWait;
            StCommit: begin
                state_d   = StLoad;
                lockcnt_d = '0;
                if (landed_q != '1) begin
                    landed_d = landed_q + 1'b1;
                end
            end
            StGameOver: tickpend_d = tickpend_q;
            default:    state_d = StStart;
        endcase
    end

    always_ff @(posedge SC_STATEMACHINE_FALLCONTROL_CLOCK_50 or
                negedge SC_STATEMACHINE_FALLCONTROL_RESET_InLow) begin
        if (!SC_STATEMACHINE_FALLCONTROL_RESET_InLow) begin
            state_q    <= StStart;
            tickpend_q <= 1'b0;
            lockcnt_q  <= '0;
            landed_q   <= '0;
        end else begin
            state_q    <= state_d;
            tickpend_q <= tickpend_d;
            lockcnt_q  <= lockcnt_d;
            landed_q   <= landed_d;
        end
    end

    assign bus_io.SC_STATEMACHINE_FALLCONTROL_loadpiece_Out  = (state_q == StLoad);
    assign bus_io.SC_STATEMACHINE_FALLCONTROL_shiftdown_Out  = (state_q == StDown);
    assign bus_io.SC_STATEMACHINE_FALLCONTROL_shiftleft_Out  = (state_q == StLeft);
    assign bus_io.SC_STATEMACHINE_FALLCONTROL_shiftright_Out = (state_q == StRight);
    assign bus_io.SC_STATEMACHINE_FALLCONTROL_commit_Out     = (state_q == StCommit);
    assign bus_io.SC_STATEMACHINE_FALLCONTROL_gameover_Out   = (state_q == StGameOver);
    assign bus_io.SC_STATEMACHINE_FALLCONTROL_landed_OutBUS  = landed_q;
endmodule
